// File: rtl/pe_bus_arbiter_mb.sv
// pe_bus_arbiter_mb
//   Arbitrates word transfers from NUM_PE processing elements onto NUM_BUSES
//   parallel lanes. Each granted word is steered to a destination PE.
//   Features: per-destination backpressure, fixed-priority or round-robin
//   search, a post-grant holdoff per source, and an OUT_STAGES-deep output
//   pipeline.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   mode       0 = fixed priority (lowest index first), 1 = round-robin
//   req_valid  per-source request
//   req_addr   per-source destination index, slice i
//   req_data   per-source data word, slice i
//   dest_full  per-destination "cannot accept" flag
//   grant      one-cycle pulse per accepted source
//   bus_valid  per-lane valid
//   bus_src    per-lane source index
//   bus_dst    per-lane destination index
//   bus_data   per-lane data word
//   rd_strobe  per-destination read strobe (OR over valid lanes)
module pe_bus_arbiter_mb #(
  parameter int NUM_PE       = 8,
  parameter int DATA_LEN     = 16,
  parameter int BUS_ADDR_LEN = 3,
  parameter int NUM_BUSES    = 2,
  parameter int HOLDOFF      = 2,
  parameter int OUT_STAGES   = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              mode,
  input  logic [NUM_PE-1:0]                 req_valid,
  input  logic [NUM_PE*BUS_ADDR_LEN-1:0]    req_addr,
  input  logic [NUM_PE*DATA_LEN-1:0]        req_data,
  input  logic [NUM_PE-1:0]                 dest_full,
  output logic [NUM_PE-1:0]                 grant,
  output logic [NUM_BUSES-1:0]              bus_valid,
  output logic [NUM_BUSES*BUS_ADDR_LEN-1:0] bus_src,
  output logic [NUM_BUSES*BUS_ADDR_LEN-1:0] bus_dst,
  output logic [NUM_BUSES*DATA_LEN-1:0]     bus_data,
  output logic [NUM_PE-1:0]                 rd_strobe
);

  localparam int AW = BUS_ADDR_LEN;
  localparam int DW = DATA_LEN;
  localparam int NB = NUM_BUSES;
  localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  // Registered copies of all request-side inputs; arbitration works on these.
  logic                 mode_reg;
  logic [NUM_PE-1:0]    valid_reg;
  logic [NUM_PE-1:0]    full_reg;
  logic [NUM_PE*AW-1:0] addr_reg;
  logic [NUM_PE*DW-1:0] data_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_reg  <= 1'b0;
      valid_reg <= '0;
      full_reg  <= '0;
      addr_reg  <= '0;
      data_reg  <= '0;
    end else begin
      mode_reg  <= mode;
      valid_reg <= req_valid;
      full_reg  <= dest_full;
      addr_reg  <= req_addr;
      data_reg  <= req_data;
    end
  end

  logic [NUM_PE-1:0]        win;         // sources winning this arbitration
  logic [NUM_PE-1:0]        elig;        // sources allowed to compete
  logic [NUM_PE*NUM_PE-1:0] dst_oh_flat; // one-hot destination per source

  // Per-source eligibility. The holdoff counter is loaded with HOLDOFF at the
  // grant edge, so it is non-zero for exactly the next HOLDOFF arbitrations;
  // that also covers the "currently in the grant register" exclusion.
  // An out-of-range destination decodes to an all-zero one-hot and can never
  // pass the backpressure test.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PE; gi++) begin : g_src
      logic [HW-1:0]     hold_cnt_reg;
      logic [NUM_PE-1:0] oh;

      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          hold_cnt_reg <= '0;
        else if (win[gi])
          hold_cnt_reg <= HW'(HOLDOFF);
        else if (hold_cnt_reg != '0)
          hold_cnt_reg <= hold_cnt_reg - HW'(1);
      end

      always_comb begin
        oh = '0;
        for (int j = 0; j < NUM_PE; j++)
          if (addr_reg[gi*AW +: AW] == AW'(j)) oh[j] = 1'b1;
      end

      assign dst_oh_flat[gi*NUM_PE +: NUM_PE] = oh;
      assign elig[gi] = valid_reg[gi] && (hold_cnt_reg == '0) &&
                        ((oh & ~full_reg) != '0);
    end
  endgenerate

  // Lane assignment: walk the search order, give each eligible source with an
  // unclaimed destination the next free lane.
  logic [AW-1:0]    rr_ptr_reg;
  logic [AW-1:0]    rr_ptr_next;
  logic [NB-1:0]    lane_valid;
  logic [NB*AW-1:0] lane_src;
  logic [NB*AW-1:0] lane_dst;
  logic [NB*DW-1:0] lane_data;

  always_comb begin
    int                lane;
    int                idx;
    logic [NUM_PE-1:0] claimed;
    logic [NUM_PE-1:0] oh;
    win         = '0;
    lane_valid  = '0;
    lane_src    = '0;
    lane_dst    = '0;
    lane_data   = '0;
    rr_ptr_next = rr_ptr_reg;
    lane        = 0;
    idx         = 0;
    claimed     = '0;
    oh          = '0;
    for (int s = 0; s < NUM_PE; s++) begin
      idx = mode_reg ? int'(rr_ptr_reg) + s : s;
      if (idx >= NUM_PE) idx = idx - NUM_PE;
      oh = dst_oh_flat[idx*NUM_PE +: NUM_PE];
      if (lane < NB && elig[idx] && ((oh & claimed) == '0)) begin
        win[idx]                 = 1'b1;
        claimed                  = claimed | oh;
        lane_valid[lane]         = 1'b1;
        lane_src[lane*AW +: AW]  = AW'(idx);
        lane_dst[lane*AW +: AW]  = addr_reg[idx*AW +: AW];
        lane_data[lane*DW +: DW] = data_reg[idx*DW +: DW];
        // Last winner in search order decides where the next search starts.
        rr_ptr_next              = (idx == NUM_PE - 1) ? '0 : AW'(idx + 1);
        lane                     = lane + 1;
      end
    end
  end

  // Grant register plus payload pipeline. Stage 0 is loaded on the grant edge,
  // stage OUT_STAGES drives the bus.
  logic [NUM_PE-1:0] grant_reg;
  logic [NB-1:0]     pv_reg [OUT_STAGES+1];
  logic [NB*AW-1:0]  ps_reg [OUT_STAGES+1];
  logic [NB*AW-1:0]  pd_reg [OUT_STAGES+1];
  logic [NB*DW-1:0]  pw_reg [OUT_STAGES+1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_reg  <= '0;
      rr_ptr_reg <= '0;
      for (int s = 0; s <= OUT_STAGES; s++) begin
        pv_reg[s] <= '0;
        ps_reg[s] <= '0;
        pd_reg[s] <= '0;
        pw_reg[s] <= '0;
      end
    end else begin
      grant_reg  <= win;
      rr_ptr_reg <= rr_ptr_next;
      pv_reg[0]  <= lane_valid;
      ps_reg[0]  <= lane_src;
      pd_reg[0]  <= lane_dst;
      pw_reg[0]  <= lane_data;
      for (int s = 1; s <= OUT_STAGES; s++) begin
        pv_reg[s] <= pv_reg[s-1];
        ps_reg[s] <= ps_reg[s-1];
        pd_reg[s] <= pd_reg[s-1];
        pw_reg[s] <= pw_reg[s-1];
      end
    end
  end

  assign grant     = grant_reg;
  assign bus_valid = pv_reg[OUT_STAGES];
  assign bus_src   = ps_reg[OUT_STAGES];
  assign bus_dst   = pd_reg[OUT_STAGES];
  assign bus_data  = pw_reg[OUT_STAGES];

  // Destinations are unique per cycle, so OR-ing lane one-hots is exact.
  always_comb begin
    rd_strobe = '0;
    for (int k = 0; k < NB; k++)
      for (int j = 0; j < NUM_PE; j++)
        if (pv_reg[OUT_STAGES][k] && (pd_reg[OUT_STAGES][k*AW +: AW] == AW'(j)))
          rd_strobe[j] = 1'b1;
  end

endmodule

// File: tb/tb_pe_bus_arbiter_mb.sv
module tb_pe_bus_arbiter_mb;

  localparam int N  = 8;
  localparam int NB = 2;
  localparam int AW = 3;
  localparam int DW = 16;
  localparam int HO = 2;
  localparam int OS = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              mode;
  logic [N-1:0]      req_valid;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      dest_full;
  logic [N-1:0]      grant;
  logic [NB-1:0]     bus_valid;
  logic [NB*AW-1:0]  bus_src;
  logic [NB*AW-1:0]  bus_dst;
  logic [NB*DW-1:0]  bus_data;
  logic [N-1:0]      rd_strobe;

  pe_bus_arbiter_mb #(
    .NUM_PE(N), .DATA_LEN(DW), .BUS_ADDR_LEN(AW),
    .NUM_BUSES(NB), .HOLDOFF(HO), .OUT_STAGES(OS)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .dest_full(dest_full), .grant(grant), .bus_valid(bus_valid),
    .bus_src(bus_src), .bus_dst(bus_dst), .bus_data(bus_data),
    .rd_strobe(rd_strobe)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct packed {
    logic [NB-1:0]    v;
    logic [NB*AW-1:0] src;
    logic [NB*AW-1:0] dst;
    logic [NB*DW-1:0] data;
  } xfer_t;

  xfer_t         dq[$];           // transfers waiting OUT_STAGES edges
  logic [N-1:0]  r_valid, r_full;
  logic [N*AW-1:0] r_addr;
  logic [N*DW-1:0] r_data;
  logic          r_mode;
  int            last_grant[N];   // edge number of each source's latest grant
  int            rr;
  int            edge_no = 0;
  logic [N-1:0]  exp_grant;
  xfer_t         exp_bus;
  logic [N-1:0]  exp_strobe;

  task automatic model_reset();
    r_valid = '0; r_full = '0; r_addr = '0; r_data = '0; r_mode = 1'b0;
    for (int i = 0; i < N; i++) last_grant[i] = -1000;
    rr = 0;
    dq.delete();
    for (int s = 0; s < OS; s++) dq.push_back('0);
  endtask

  task automatic model_step();
    xfer_t        nx;
    int           lanes, i, a, last;
    logic [N-1:0] used;
    nx = '0; lanes = 0; used = '0; last = -1; exp_grant = '0;
    for (int k = 0; k < N; k++) begin
      i = r_mode ? (rr + k) % N : k;
      a = int'(r_addr[i*AW +: AW]);
      if (lanes < NB && r_valid[i] && (edge_no - last_grant[i] > HO) &&
          a < N && !r_full[a] && !used[a]) begin
        nx.v[lanes]               = 1'b1;
        nx.src[lanes*AW +: AW]    = AW'(i);
        nx.dst[lanes*AW +: AW]    = AW'(a);
        nx.data[lanes*DW +: DW]   = r_data[i*DW +: DW];
        used[a]       = 1'b1;
        exp_grant[i]  = 1'b1;
        last_grant[i] = edge_no;
        last          = i;
        lanes++;
      end
    end
    if (last >= 0) rr = (last + 1) % N;
    dq.push_back(nx);
    exp_bus = dq.pop_front();
    r_valid = req_valid; r_full = dest_full; r_addr = req_addr;
    r_data  = req_data;  r_mode = mode;
  endtask

  // Model advance and per-cycle comparison, sampled 1 ns after each edge.
  always @(posedge clk) begin
    edge_no++;
    if (rst) begin
      model_reset();
      exp_grant = '0;
      exp_bus   = '0;
    end else begin
      model_step();
    end
    exp_strobe = '0;
    for (int k = 0; k < NB; k++)
      if (exp_bus.v[k]) exp_strobe[int'(exp_bus.dst[k*AW +: AW])] = 1'b1;
    #1;
    check("grant",     64'(grant),     64'(exp_grant));
    check("bus_valid", 64'(bus_valid), 64'(exp_bus.v));
    check("bus_src",   64'(bus_src),   64'(exp_bus.src));
    check("bus_dst",   64'(bus_dst),   64'(exp_bus.dst));
    check("bus_data",  64'(bus_data),  64'(exp_bus.data));
    check("rd_strobe", 64'(rd_strobe), 64'(exp_strobe));
    for (int k = 0; k < NB; k++)
      if (exp_bus.v[k])
        $display("xfer t=%0t lane %0d src %0d dst %0d data %h", $time, k,
                 exp_bus.src[k*AW +: AW], exp_bus.dst[k*AW +: AW],
                 exp_bus.data[k*DW +: DW]);
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    req_valid = '0; req_addr = '0; req_data = '0; dest_full = '0;
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  function automatic logic [63:0] all_out();
    return 64'({grant, bus_valid, bus_src, bus_dst, bus_data, rd_strobe});
  endfunction

  initial begin
    rst = 1'b1; mode = 1'b0;
    idle();
    model_reset();

    // 1. reset with random inputs, then idle after release
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      req_valid = N'($urandom); req_addr = (N*AW)'($urandom);
      req_data  = {$urandom, $urandom, $urandom, $urandom};
      dest_full = N'($urandom); mode = 1'($urandom);
      wait_edges(1);
      check("reset_outputs", all_out(), 64'd0);
    end
    @(negedge clk);
    rst = 1'b0; mode = 1'b0; idle();
    for (int c = 0; c < 5; c++) begin
      wait_edges(1);
      check("idle_outputs", all_out(), 64'd0);
    end

    // 2. single transfer PE3 -> 5
    @(negedge clk);
    req_valid[3] = 1'b1; req_addr[3*AW +: AW] = 3'd5; req_data[3*DW +: DW] = 16'hABCD;
    wait_edges(2);
    check("single_grant", 64'(grant), 64'h08);
    @(negedge clk); idle();
    wait_edges(2);
    check("single_valid",  64'(bus_valid), 64'h1);
    check("single_src",    64'(bus_src[AW-1:0]), 64'd3);
    check("single_dst",    64'(bus_dst[AW-1:0]), 64'd5);
    check("single_data",   64'(bus_data[DW-1:0]), 64'hABCD);
    check("single_strobe", 64'(rd_strobe), 64'h20);
    wait_edges(4);

    // 3. destination conflict, fixed priority
    @(negedge clk);
    req_valid = 8'h06;
    req_addr[1*AW +: AW] = 3'd4; req_addr[2*AW +: AW] = 3'd4;
    req_data[1*DW +: DW] = 16'h1111; req_data[2*DW +: DW] = 16'h2222;
    wait_edges(2); check("conflict_e2", 64'(grant), 64'h02);
    wait_edges(1); check("conflict_e3", 64'(grant), 64'h04);
    wait_edges(1); check("conflict_e4", 64'(grant), 64'h00);
    wait_edges(1); check("conflict_e5", 64'(grant), 64'h02);
    @(negedge clk); idle();
    wait_edges(6);

    // 4. parallel lanes
    @(negedge clk);
    req_valid = 8'h81;
    req_addr[0*AW +: AW] = 3'd6; req_addr[7*AW +: AW] = 3'd2;
    req_data[0*DW +: DW] = 16'h0A0A; req_data[7*DW +: DW] = 16'h7B7B;
    wait_edges(2); check("parallel_grant", 64'(grant), 64'h81);
    @(negedge clk); idle();
    wait_edges(2);
    check("parallel_valid",  64'(bus_valid), 64'h3);
    check("parallel_src",    64'(bus_src), 64'h38);
    check("parallel_dst",    64'(bus_dst), 64'h16);
    check("parallel_strobe", 64'(rd_strobe), 64'h44);
    wait_edges(4);

    // 5. backpressure
    @(negedge clk);
    req_valid[2] = 1'b1; req_addr[2*AW +: AW] = 3'd3; req_data[2*DW +: DW] = 16'h5555;
    dest_full = 8'h08;
    for (int c = 0; c < 5; c++) begin
      wait_edges(1);
      check("bp_blocked", 64'(grant), 64'h00);
    end
    @(negedge clk); dest_full = '0;
    wait_edges(2); check("bp_release", 64'(grant), 64'h04);
    @(negedge clk); idle();
    wait_edges(6);

    // 6. round-robin with a mid-run reset
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; mode = 1'b1; req_valid = 8'hFF;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = AW'((i + 3) % N);
      req_data[i*DW +: DW] = DW'($urandom);
    end
    wait_edges(2); check("rr_pair0", 64'(grant), 64'h03);
    wait_edges(1); check("rr_pair1", 64'(grant), 64'h0C);
    wait_edges(1); check("rr_pair2", 64'(grant), 64'h30);
    wait_edges(1); check("rr_pair3", 64'(grant), 64'hC0);
    wait_edges(1); check("rr_pair4", 64'(grant), 64'h03);
    wait_edges(1);
    @(negedge clk); rst = 1'b1;
    #1 check("rr_async_reset", all_out(), 64'd0);
    @(negedge clk); rst = 1'b0;
    wait_edges(2); check("rr_after_reset", 64'(grant), 64'h03);
    wait_edges(1); check("rr_after_reset2", 64'(grant), 64'h0C);
    @(negedge clk); idle(); mode = 1'b0;
    wait_edges(6);

    // 7. randomized traffic, checked every cycle by the model
    for (int c = 0; c < 1200; c++) begin
      @(negedge clk);
      rst       = ($urandom_range(0, 149) == 0);
      req_valid = N'($urandom);
      req_addr  = (N*AW)'($urandom);
      req_data  = {$urandom, $urandom, $urandom, $urandom};
      dest_full = N'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 19) == 0) mode = ~mode;
    end
    @(negedge clk); rst = 1'b0; idle();
    wait_edges(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
